// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache line controller and its beat counter.
package cache_pkg;

  // Controller states; the replayed request completes in ST_IDLE after ST_RESUME.
  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WRITEBACK    = 3'd1,
    ST_REFILL       = 3'd2,
    ST_RESUME       = 3'd3,
    ST_WRITE_AROUND = 3'd4
  } cache_state_t;

  // Memory command encoding, bit 1 = request valid, bit 0 = write.
  typedef enum logic [1:0] {
    MEM_CMD_NONE  = 2'b00,
    MEM_CMD_READ  = 2'b10,
    MEM_CMD_WRITE = 2'b11
  } mem_cmd_t;

  // Number of words in a line for a given word-select width.
  function automatic int unsigned n_words(input int unsigned word_sel_w);
    return 32'd1 << word_sel_w;
  endfunction

endpackage

// File: rtl/mem_beat_counter.sv
// Per-word beat counter for memory bursts: counts accepted beats and flags the
// final beat of a line. Clear has priority over increment.
module mem_beat_counter
  import cache_pkg::*;
#(
  parameter int WORD_SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  inc,
  output logic [WORD_SEL_W-1:0] beat_offset,
  output logic                  last
);

  localparam int unsigned N_WORDS  = n_words(WORD_SEL_W);
  localparam int unsigned LAST_IDX = N_WORDS - 32'd1;
  localparam logic [WORD_SEL_W:0] LAST_CNT = LAST_IDX[WORD_SEL_W:0];
  localparam logic [WORD_SEL_W:0] CNT_ONE  = {{WORD_SEL_W{1'b0}}, 1'b1};

  logic [WORD_SEL_W:0] count_d;
  logic [WORD_SEL_W:0] count_q;

  // Next count: clear on burst start/end, advance on each accepted beat.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign beat_offset = count_q[WORD_SEL_W-1:0];
  assign last        = (count_q == LAST_CNT);

endmodule

// File: rtl/cache_line_ctrl.sv
// Write-back cache line controller: zero-latency hits, per-word victim
// write-back and refill over a ready/valid memory port, optional write-around
// on write misses. Outputs are combinational from state, beat count and inputs.
module cache_line_ctrl
  import cache_pkg::*;
#(
  parameter int WORD_SEL_W     = 2,
  parameter bit WRITE_ALLOCATE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  cw_en,
  input  logic                  hit,
  input  logic                  dirty,
  input  logic [WORD_SEL_W-1:0] block_offset,
  input  logic                  mem_ready,
  output logic                  stall,
  output logic                  w_en,
  output logic                  set_valid,
  output logic                  set_dirty,
  output logic                  strategy_en,
  output logic [WORD_SEL_W-1:0] offset,
  output logic                  fill_sel,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  victim_sel
);

  cache_state_t state_d;
  cache_state_t state_q;
  // Write-around mode latched at miss entry so cw_en is only sampled in IDLE;
  // it is an extension of the state, selecting the exit of WRITEBACK.
  logic         around_d;
  logic         around_q;

  mem_cmd_t              mem_cmd;
  logic                  beat_clr;
  logic                  beat_inc;
  logic                  beat_last;
  logic [WORD_SEL_W-1:0] beat_offset;

  assign beat_inc = mem_ready & ((state_q == ST_WRITEBACK) | (state_q == ST_REFILL));
  assign beat_clr = ((state_q == ST_IDLE) & en & ~hit) | (beat_inc & beat_last);

  mem_beat_counter #(
    .WORD_SEL_W (WORD_SEL_W)
  ) u_beat_counter (
    .clk         (clk),
    .reset       (reset),
    .clr         (beat_clr),
    .inc         (beat_inc),
    .beat_offset (beat_offset),
    .last        (beat_last)
  );

  // Next-state and output decode; all outputs forced low while reset is held.
  always_comb begin
    state_d     = state_q;
    around_d    = around_q;
    stall       = 1'b0;
    w_en        = 1'b0;
    set_valid   = 1'b0;
    set_dirty   = 1'b0;
    strategy_en = 1'b0;
    offset      = '0;
    fill_sel    = 1'b0;
    victim_sel  = 1'b0;
    mem_cmd     = MEM_CMD_NONE;
    if (!reset) begin
      state_d  = ST_IDLE;
      around_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            if (hit) begin
              w_en        = cw_en;
              set_valid   = 1'b1;
              set_dirty   = dirty | cw_en;
              strategy_en = 1'b1;
              offset      = block_offset;
            end else begin
              stall    = 1'b1;
              around_d = cw_en & ~WRITE_ALLOCATE;
              if (dirty) begin
                state_d = ST_WRITEBACK;
              end else if (cw_en && !WRITE_ALLOCATE) begin
                state_d = ST_WRITE_AROUND;
              end else begin
                state_d = ST_REFILL;
              end
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WRITEBACK: begin
          stall      = 1'b1;
          mem_cmd    = MEM_CMD_WRITE;
          victim_sel = 1'b1;
          offset     = beat_offset;
          if (mem_ready && beat_last) begin
            set_valid = 1'b1;
            set_dirty = 1'b0;
            state_d   = around_q ? ST_WRITE_AROUND : ST_REFILL;
          end else begin
            state_d = ST_WRITEBACK;
          end
        end
        ST_REFILL: begin
          stall    = 1'b1;
          mem_cmd  = MEM_CMD_READ;
          fill_sel = 1'b1;
          offset   = beat_offset;
          w_en     = mem_ready;
          if (mem_ready && beat_last) begin
            set_valid = 1'b1;
            set_dirty = 1'b0;
            state_d   = ST_RESUME;
          end else begin
            state_d = ST_REFILL;
          end
        end
        ST_RESUME: begin
          stall   = 1'b1;
          state_d = ST_IDLE;
        end
        ST_WRITE_AROUND: begin
          mem_cmd = MEM_CMD_WRITE;
          offset  = block_offset;
          stall   = ~mem_ready;
          if (mem_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WRITE_AROUND;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          around_d = 1'b0;
        end
      endcase
    end
  end

  assign {mem_req, mem_we} = mem_cmd;

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      around_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      around_q <= around_d;
    end
  end

endmodule

// File: doc/cache_line_ctrl.md
Name: cache_line_ctrl

Overview:
- Parametrised write-back cache controller FSM. Successor to the fixed 4-word, fixed-latency controller.
- Sits between one cache set/line array and the memory port.
- Drives line write enables, valid/dirty updates, word offset and replacement-strategy update.
- Runs a per-word ready/valid handshake to memory for victim write-back and line refill.
- Adds a stall output, variable memory latency and an optional write-no-allocate mode.

Parameters:
WORD_SEL_W, 2, log2(words per line); line holds 2**WORD_SEL_W words; legal range 1..4
WRITE_ALLOCATE, 1, 1: write miss refills the line; 0: write miss is a single-word write-around to memory, no fill

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
en  in  1  request valid this cycle (cache access enable)
cw_en  in  1  request is a write
hit  in  1  addressed line present (from set)
dirty  in  1  replacement victim dirty (from set)
block_offset  in  WORD_SEL_W  word offset of request
mem_ready  in  1  memory accepted/returned current word this cycle
stall  out  1  request not completing this cycle; pipeline must hold
w_en  out  1  write enable to line data array
set_valid  out  1  line valid update
set_dirty  out  1  line dirty update
strategy_en  out  1  replacement state update (one pulse per completed access)
offset  out  WORD_SEL_W  word offset to line array and memory
fill_sel  out  1  1: line write data from memory; 0: from CPU
mem_req  out  1  memory request valid
mem_we  out  1  memory request is write
victim_sel  out  1  1: memory address uses victim tag; 0: request tag

Behaviour:
- State/count registers:
  - state in {IDLE, WRITEBACK, REFILL, RESUME, WRITE_AROUND}; count is WORD_SEL_W+1 bits.
  - Reset (reset=0, async): state=IDLE, count=0. While reset is low every output is 0.
- Outputs are combinational from state, count and inputs. Only state and count are registered.
- IDLE, en=0: all outputs 0; no state change.
- IDLE, en=1, hit=1 (zero-latency hit):
  - stall=0, w_en=cw_en, set_valid=1, set_dirty=dirty|cw_en, strategy_en=1, offset=block_offset, fill_sel=0.
- IDLE, en=1, hit=0:
  - stall=1.
  - Next state: WRITEBACK if dirty; else WRITE_AROUND if cw_en and WRITE_ALLOCATE=0; else REFILL.
  - count<=0.
- WRITEBACK:
  - Outputs: stall=1, mem_req=1, mem_we=1, victim_sel=1, offset=count.
  - On mem_ready: count++.
  - On mem_ready with count==N-1 (N=2**WORD_SEL_W):
    - set_valid=1, set_dirty=0 that cycle.
    - Next: WRITE_AROUND if cw_en and WRITE_ALLOCATE=0, else REFILL; count<=0.
- REFILL:
  - Outputs: stall=1, mem_req=1, mem_we=0, fill_sel=1, offset=count, w_en=mem_ready.
  - On mem_ready: count++.
  - On mem_ready with count==N-1: set_valid=1, set_dirty=0; next RESUME; count<=0.
- RESUME (one cycle): stall=1, all writes 0. Next IDLE, where the replayed request hits.
- WRITE_AROUND:
  - Outputs: stall=1, mem_req=1, mem_we=1, victim_sel=0, offset=block_offset.
  - On mem_ready: strategy_en=0, stall=0 (request retires); next IDLE. The line array is untouched.
- Memory wait: mem_ready low holds state, count and all outputs stable. No timeout.
- en deasserted mid-miss: ignored. A started memory transaction always completes; en/cw_en are sampled only in IDLE, so the mode chosen at IDLE entry is kept through WRITEBACK.
- count never wraps. It resets to 0 on every transition out of WRITEBACK/REFILL.
- hit/dirty are ignored outside IDLE.

Decomposition:
- Shared package cache_pkg:
  - state enum cache_state_t;
  - localparam N_WORDS = 2**WORD_SEL_W helper function;
  - memory command encoding.
- Sub-module: mem_beat_counter (count, increment on mem_ready, last-beat flag). Reused by the future DMA/prefetch block.

Test Plan:
- Read hit (en=1, hit=1, cw_en=0, block_offset=2) -> same cycle stall=0, strategy_en=1, offset=2, w_en=0, no mem_req.
- Write hit on clean line (cw_en=1, dirty=0) -> w_en=1, set_dirty=1, stall=0.
- Clean read miss, WORD_SEL_W=2, mem_ready every cycle -> stall high 6 cycles. REFILL offsets 0,1,2,3 with w_en=1, fill_sel=1. set_valid on the 4th beat, then RESUME, then the hit completes.
- Dirty miss, WORD_SEL_W=3, mem_ready asserted every 3rd cycle -> 8 write beats (mem_we=1, victim_sel=1, offsets 0..7) then 8 read beats. Outputs are stable during wait cycles. Total stall = 48+1 cycles +1 RESUME.
- WRITE_ALLOCATE=0, clean write miss, block_offset=1 -> single mem_we beat at offset 1, w_en never asserted, back to IDLE after mem_ready.
- Assert reset low mid-REFILL (count=2) -> outputs 0 immediately. After release: state IDLE, count 0, next miss starts at offset 0.
